// File: rtl/rho_lane_streamer.sv
// Rho-offset lane streamer: holds a 25-lane bank and feeds each lane, rotated by
// its fixed rho offset, to the bit-slice collector, then pulses the file-dump strobe.

module rho_lane #(
  parameter int LANE_W = 64,
  parameter int OFS    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [LANE_W-1:0] d,
  output logic [LANE_W-1:0] rot
);
  localparam int S = OFS % LANE_W;

  logic [LANE_W-1:0] q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (we) q <= d;
  end

  // Constant rotation: pure wiring, no shifter
  if (S == 0) begin : g_norot
    assign rot = q;
  end else begin : g_rot
    assign rot = (q << S) | (q >> (LANE_W - S));
  end
endmodule

module rho_lane_streamer #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [4:0]        wrAddr,
  input  logic [LANE_W-1:0] wrData,
  input  logic              start,
  output logic              busy,
  output logic              ldn,
  output logic [31:0]       number,
  output logic [LANE_W-1:0] nOut,
  output logic              writeToFile,
  output logic              done,
  output logic              err
);
  localparam logic [4:0] LAST = 5'(NUM_LANES - 1);

  function automatic int rho_ofs(input int i);
    case (i)
      0:  return 0;   1:  return 1;   2:  return 62;  3:  return 28;  4:  return 27;
      5:  return 36;  6:  return 44;  7:  return 6;   8:  return 55;  9:  return 20;
      10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
      15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
      20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
      default: return 0;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} st_t;

  st_t                                state;
  logic [4:0]                         idx;
  logic                               wr_ok;
  logic [NUM_LANES-1:0]               lane_we;
  logic [NUM_LANES-1:0][LANE_W-1:0]   lane_rot;

  assign wr_ok = wrEn && (state == IDLE) && (wrAddr <= LAST);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_we[g] = wr_ok && (wrAddr == 5'(g));
    rho_lane #(.LANE_W(LANE_W), .OFS(rho_ofs(g))) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (lane_we[g]),
      .d   (wrData),
      .rot (lane_rot[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      ldn         <= 1'b0;
      number      <= '0;
      nOut        <= '0;
      writeToFile <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      ldn         <= 1'b0;
      writeToFile <= 1'b0;
      done        <= 1'b0;
      err         <= wrEn && ((state != IDLE) || (wrAddr > LAST));
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          ldn    <= 1'b1;
          number <= 32'(idx);
          nOut   <= lane_rot[idx];
          if (idx == LAST) begin
            state <= FLUSH;
            idx   <= '0;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        FLUSH: begin
          writeToFile <= 1'b1;
          done        <= 1'b1;
          // The FLUSH exit edge is also the first edge a new start may be taken,
          // giving back-to-back streams a 26-cycle period.
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rho_lane_streamer.sv
// Directed bench for rho_lane_streamer: rotation table vectors plus hand-written
// sequences for rejected writes, same-edge write/start, mid-stream reset, back-to-back.

module tb_rho_lane_streamer;
  logic        clk, rst, wrEn, start;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic        busy, ldn, writeToFile, done, err;
  logic [31:0] number;
  logic [63:0] nOut;

  rho_lane_streamer #(.LANE_W(64), .NUM_LANES(25)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .start(start), .busy(busy), .ldn(ldn), .number(number), .nOut(nOut),
    .writeToFile(writeToFile), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  lane;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  int          ldn_num[$];
  int          ldn_cyc[$];
  logic [63:0] ldn_val[$];
  int          done_c[$];
  int          err_c[$];
  int          ovl, busy0, busy_fall;
  logic [63:0] ref_val[25];

  task automatic write_lane(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = a; wrData = d;
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  // Cycle c samples just after edge E0+c; start is driven before E0.
  task automatic run(input int ncyc, input int wr_at, input logic [4:0] wa,
                     input logic [63:0] wd, input int st_at);
    ldn_num.delete(); ldn_cyc.delete(); ldn_val.delete();
    done_c.delete(); err_c.delete();
    ovl = 0; busy0 = 0; busy_fall = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start  = (c == 0) || (c == st_at);
      wrEn   = (c == wr_at);
      wrAddr = wa;
      wrData = wd;
      @(posedge clk); #1;
      if (ldn) begin
        ldn_num.push_back(int'(number));
        ldn_cyc.push_back(c);
        ldn_val.push_back(nOut);
      end
      if ((ldn && writeToFile) || (writeToFile !== done)) ovl++;
      if (done) done_c.push_back(c);
      if (err)  err_c.push_back(c);
      if (c == 0) busy0 = int'(busy);
      if (!busy && busy_fall < 0) busy_fall = c;
    end
    start = 1'b0;
    wrEn  = 1'b0;
  endtask

  task automatic chk_seq(input string name, input int nblk);
    int bad;
    bad = 0;
    foreach (ldn_num[k])
      if (ldn_num[k] != k % 25 || ldn_cyc[k] != (k / 25) * 26 + k % 25 + 1) bad++;
    chk({name, "_nldn"}, 64'(ldn_num.size()), 64'(25 * nblk));
    chk({name, "_order"}, 64'(bad), 64'd0);
    chk({name, "_overlap"}, 64'(ovl), 64'd0);
  endtask

  function automatic logic [63:0] val_of(input int n);
    foreach (ldn_num[k]) if (ldn_num[k] == n) return ldn_val[k];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, hit, nw;
    logic [63:0] acc;

    vecs[0] = '{5'd0,  64'h1, 64'h1};
    vecs[1] = '{5'd1,  64'h1, 64'h2};
    vecs[2] = '{5'd2,  64'h1, 64'h4000_0000_0000_0000};
    vecs[3] = '{5'd3,  64'hF000_0000_0000_0000, 64'h0000_0000_0F00_0000};
    vecs[4] = '{5'd4,  64'h1, 64'h0000_0000_0800_0000};
    vecs[5] = '{5'd7,  64'h1, 64'h40};
    vecs[6] = '{5'd8,  64'h1, 64'h0080_0000_0000_0000};
    vecs[7] = '{5'd13, 64'h1, 64'h0000_0000_0200_0000};
    vecs[8] = '{5'd24, 64'h1, 64'h4000};

    rst = 1'b0; wrEn = 1'b0; start = 1'b0; wrAddr = '0; wrData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 64'({busy, ldn, writeToFile, done, err}), 64'd0);
    chk("rst_number", 64'(number), 64'd0);
    chk("rst_nout", nOut, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Bank of ones, then table overrides; stream and compare per table entry
    for (int i = 0; i < 25; i++) write_lane(5'(i), 64'h1);
    foreach (vecs[v]) write_lane(vecs[v].lane, vecs[v].wdata);
    run(30, -1, 5'd0, 64'd0, -1);
    chk("a_busy_e0", 64'(busy0), 64'd1);
    chk_seq("a", 1);
    chk("a_ndone", 64'(done_c.size()), 64'd1);
    if (done_c.size() > 0) chk("a_done_cyc", 64'(done_c[0]), 64'd26);
    chk("a_busy_fall", 64'(busy_fall), 64'd26);
    foreach (vecs[v]) chk($sformatf("a_lane%0d", vecs[v].lane), val_of(int'(vecs[v].lane)), vecs[v].exp);
    for (int n = 0; n < 25; n++) ref_val[n] = val_of(n);

    // Out-of-range write in IDLE
    write_lane(5'd0, 64'h8000_0000_0000_0001);
    write_lane(5'd25, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_err_pulse", 64'(err), 64'd1);
    @(posedge clk); #1;
    chk("b_err_clear", 64'(err), 64'd0);
    run(30, -1, 5'd0, 64'd0, -1);
    chk_seq("b", 1);
    chk("b_lane0", val_of(0), 64'h8000_0000_0000_0001);
    bad = 0;
    for (int n = 1; n < 25; n++) if (val_of(n) !== ref_val[n]) bad++;
    chk("b_bank_same", 64'(bad), 64'd0);

    // Write and start while streaming
    run(30, 5, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 10);
    chk_seq("c", 1);
    chk("c_ndone", 64'(done_c.size()), 64'd1);
    chk("c_nerr", 64'(err_c.size()), 64'd1);
    if (err_c.size() > 0) chk("c_err_cyc", 64'(err_c[0]), 64'd5);
    chk("c_lane0", val_of(0), 64'h8000_0000_0000_0001);

    // Same-edge write and start
    run(30, 0, 5'd5, 64'h1, -1);
    chk_seq("d", 1);
    chk("d_nerr", 64'(err_c.size()), 64'd0);
    chk("d_lane5", val_of(5), 64'h0000_0010_0000_0000);

    // Back-to-back streams
    for (int n = 0; n < 25; n++) ref_val[n] = val_of(n);
    run(60, -1, 5'd0, 64'd0, 26);
    chk_seq("e", 2);
    chk("e_ndone", 64'(done_c.size()), 64'd2);
    if (done_c.size() == 2) chk("e_done_gap", 64'(done_c[1] - done_c[0]), 64'd26);
    bad = 0;
    foreach (ldn_val[k]) if (ldn_val[k] !== ref_val[k % 25]) bad++;
    chk("e_same_data", 64'(bad), 64'd0);

    // Asynchronous reset mid-stream
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    hit = 0;
    for (int k = 0; k < 40 && hit == 0; k++) begin
      @(posedge clk); #1;
      if (ldn && number == 32'd10) hit = 1;
    end
    chk("f_reach10", 64'(hit), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("f_flags", 64'({busy, ldn, writeToFile, done, err}), 64'd0);
    chk("f_number", 64'(number), 64'd0);
    chk("f_nout", nOut, 64'd0);
    @(negedge clk); rst = 1'b1;
    nw = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (writeToFile || done || ldn) nw++;
    end
    chk("f_no_dump", 64'(nw), 64'd0);
    run(30, -1, 5'd0, 64'd0, -1);
    chk_seq("f", 1);
    acc = '0;
    foreach (ldn_val[k]) acc |= ldn_val[k];
    chk("f_bank_zero", acc, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
